// File: rtl/cu_pkg.sv
// Shared types for the hazard-aware control unit: control word, bubble constant, forward selects.
// Latency: none (types and constants only).
// Backpressure: none.
package cu_pkg;

    localparam int INSTR_SIZE = 32;

    // RV32-style major opcodes understood by the decoder
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    // ALU operation is {funct7[5], funct3} for register ops; the extras below cover the rest
    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       reg_we;
        logic       mem_rd;
        logic       mem_wr;
        logic       is_jump;
        logic       is_branch;
        logic       uses_rs1;
        logic       uses_rs2;
    } cw_t;

    localparam int  CW_LENGTH = $bits(cw_t);

    // A bubble: no register or memory side effects
    localparam cw_t NOP = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/cw_decoder.sv
// Opcode/funct to control word translation for the instruction sitting in IF/ID.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the word is used or replaced by a bubble.
module cw_decoder
    import cu_pkg::*;
(
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    output logic [CW_LENGTH-1:0] cw
);

    cw_t dec;

    // Unknown opcodes decode to a bubble so they can never write state
    always_comb begin
        dec = NOP;
        case (opcode)
            OPC_OP: begin
                dec.alu_op   = {funct7b5, funct3};
                dec.reg_we   = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                // funct7[5] only selects arithmetic shift; elsewhere it is immediate data
                dec.alu_op   = {funct7b5 & (funct3 == 3'b101), funct3};
                dec.reg_we   = 1'b1;
                dec.uses_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_op   = ALU_ADD;
                dec.reg_we   = 1'b1;
                dec.mem_rd   = 1'b1;
                dec.uses_rs1 = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_op   = ALU_ADD;
                dec.mem_wr   = 1'b1;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
            end
            OPC_JAL: begin
                dec.alu_op  = ALU_ADD;
                dec.reg_we  = 1'b1;
                dec.is_jump = 1'b1;
            end
            OPC_JALR: begin
                dec.alu_op   = ALU_ADD;
                dec.reg_we   = 1'b1;
                dec.is_jump  = 1'b1;
                dec.uses_rs1 = 1'b1;
            end
            OPC_LUI: begin
                dec.alu_op = ALU_PASS_B;
                dec.reg_we = 1'b1;
            end
            default: dec = NOP;
        endcase
    end

    assign cw = dec;

endmodule

// File: rtl/cu_hazard.sv
// Control unit: decodes IF/ID, pipelines control through EX/MEM/WB, and owns interlock, forwarding and front-end flush.
// Latency: instruction sampled at edge n is in cw_ex after n, cw_mem after n+1, cw_wb after n+2; hazard outputs are combinational.
// Backpressure: stall_in freezes every stage register; internal hazards hold the front end via stall_fe and inject bubbles into EX.
module cu_hazard
    import cu_pkg::*;
#(
    parameter int INSTR_W  = INSTR_SIZE,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [INSTR_W-1:0]   instr_in,
    input  logic                 stall_in,
    input  logic                 branch_taken,
    output logic [CW_LENGTH-1:0] cw_ex,
    output logic [CW_LENGTH-1:0] cw_mem,
    output logic [CW_LENGTH-1:0] cw_wb,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 stall_fe,
    output logic                 flush_fe
);

    localparam logic USE_FWD  = (FWD_EN != 0);
    // With a two-stage load latency a load still sitting in MEM cannot be forwarded
    localparam logic LOAD_MEM = (LOAD_LAT >= 2);

    // ID stage: decoded word and register fields
    cw_t               id_cw;
    logic [REG_AW-1:0] id_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              unused_instr;

    // Stage registers; destination/source fields are zeroed when not meaningful
    cw_t               ex_cw;
    cw_t               mem_cw;
    cw_t               wb_cw;
    logic [REG_AW-1:0] ex_dst;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] mem_dst;
    logic [REG_AW-1:0] wb_dst;

    logic id_hit_ex;
    logic id_hit_mem;
    logic ex_prod;
    logic mem_prod;
    logic hazard;
    logic kill;
    logic mem_fwd_ok;
    logic wb_fwd_ok;

    cw_decoder u_dec (
        .opcode   (instr_in[6:0]),
        .funct3   (instr_in[14:12]),
        .funct7b5 (instr_in[30]),
        .cw       (id_cw)
    );

    assign id_rd        = instr_in[7 +: REG_AW];
    assign id_rs1       = instr_in[15 +: REG_AW];
    assign id_rs2       = instr_in[20 +: REG_AW];
    assign unused_instr = ^instr_in;

    // Interlock: compare ID sources against producers that cannot yet supply data.
    // WB never participates because the register file is write-first.
    assign id_hit_ex  = (id_cw.uses_rs1 && id_rs1 == ex_dst)  || (id_cw.uses_rs2 && id_rs2 == ex_dst);
    assign id_hit_mem = (id_cw.uses_rs1 && id_rs1 == mem_dst) || (id_cw.uses_rs2 && id_rs2 == mem_dst);
    assign ex_prod    = ex_cw.reg_we  && (ex_dst  != '0) && (!USE_FWD || ex_cw.mem_rd);
    assign mem_prod   = mem_cw.reg_we && (mem_dst != '0) && (USE_FWD ? (LOAD_MEM && mem_cw.mem_rd) : 1'b1);
    assign hazard     = (ex_prod && id_hit_ex) || (mem_prod && id_hit_mem);

    // A taken branch overrides the interlock: the ID instruction is discarded, not held
    assign kill     = branch_taken || hazard;
    assign stall_fe = stall_in || (hazard && !branch_taken);
    assign flush_fe = !stall_in && (branch_taken || (id_cw.is_jump && !hazard));

    // A load in MEM is never a forwarding source; the interlock keeps consumers away from it
    assign mem_fwd_ok = mem_cw.reg_we && !mem_cw.mem_rd;
    assign wb_fwd_ok  = wb_cw.reg_we;

    // Operand source select for the EX instruction, MEM taking priority over WB
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (USE_FWD) begin
            if (ex_cw.uses_rs1 && ex_rs1 != '0) begin
                if (mem_fwd_ok && mem_dst == ex_rs1)    fwd_a = FWD_MEM;
                else if (wb_fwd_ok && wb_dst == ex_rs1) fwd_a = FWD_WB;
            end
            if (ex_cw.uses_rs2 && ex_rs2 != '0) begin
                if (mem_fwd_ok && mem_dst == ex_rs2)    fwd_b = FWD_MEM;
                else if (wb_fwd_ok && wb_dst == ex_rs2) fwd_b = FWD_WB;
            end
        end
    end

    // Pipeline advance; stall_in freezes everything, kill replaces the EX entry with a bubble
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ex_cw   <= NOP;
            mem_cw  <= NOP;
            wb_cw   <= NOP;
            ex_dst  <= '0;
            ex_rs1  <= '0;
            ex_rs2  <= '0;
            mem_dst <= '0;
            wb_dst  <= '0;
        end else if (!stall_in) begin
            wb_cw   <= mem_cw;
            wb_dst  <= mem_dst;
            mem_cw  <= ex_cw;
            mem_dst <= ex_dst;
            if (kill) begin
                ex_cw  <= NOP;
                ex_dst <= '0;
                ex_rs1 <= '0;
                ex_rs2 <= '0;
            end else begin
                ex_cw  <= id_cw;
                ex_dst <= id_cw.reg_we   ? id_rd  : '0;
                ex_rs1 <= id_cw.uses_rs1 ? id_rs1 : '0;
                ex_rs2 <= id_cw.uses_rs2 ? id_rs2 : '0;
            end
        end
    end

    assign cw_ex  = ex_cw;
    assign cw_mem = mem_cw;
    assign cw_wb  = wb_cw;

endmodule

// File: tb/tb_cu_hazard.sv
// Directed bench for cu_hazard: three instances (forwarding with load latency 1 and 2, and no forwarding).
// Each instance has its own IF/ID input; stall_in and branch_taken are shared.
module tb_cu_hazard;
    import cu_pkg::*;

    // Hand-computed control words: {alu_op[10:7], reg_we, mem_rd, mem_wr, is_jump, is_branch, uses_rs1, uses_rs2}
    localparam logic [CW_LENGTH-1:0] CW_NOP = 11'h000;
    localparam logic [CW_LENGTH-1:0] CW_ADD = 11'h043;
    localparam logic [CW_LENGTH-1:0] CW_LW  = 11'h062;
    localparam logic [CW_LENGTH-1:0] CW_JAL = 11'h048;

    logic clk = 1'b0;
    logic nrst;
    logic stall_in;
    logic branch_taken;
    logic [31:0] instr_a, instr_b, instr_c;

    logic [CW_LENGTH-1:0] a_cw_ex, a_cw_mem, a_cw_wb, b_cw_ex, b_cw_mem, b_cw_wb, c_cw_ex, c_cw_mem, c_cw_wb;
    logic [1:0] a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b, c_fwd_a, c_fwd_b;
    logic a_stall_fe, a_flush_fe, b_stall_fe, b_flush_fe, c_stall_fe, c_flush_fe;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cu_hazard #(.LOAD_LAT(1), .FWD_EN(1)) u_a (
        .clk(clk), .nrst(nrst), .instr_in(instr_a), .stall_in(stall_in), .branch_taken(branch_taken),
        .cw_ex(a_cw_ex), .cw_mem(a_cw_mem), .cw_wb(a_cw_wb), .fwd_a(a_fwd_a), .fwd_b(a_fwd_b),
        .stall_fe(a_stall_fe), .flush_fe(a_flush_fe));

    cu_hazard #(.LOAD_LAT(2), .FWD_EN(1)) u_b (
        .clk(clk), .nrst(nrst), .instr_in(instr_b), .stall_in(stall_in), .branch_taken(branch_taken),
        .cw_ex(b_cw_ex), .cw_mem(b_cw_mem), .cw_wb(b_cw_wb), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
        .stall_fe(b_stall_fe), .flush_fe(b_flush_fe));

    cu_hazard #(.LOAD_LAT(1), .FWD_EN(0)) u_c (
        .clk(clk), .nrst(nrst), .instr_in(instr_c), .stall_in(stall_in), .branch_taken(branch_taken),
        .cw_ex(c_cw_ex), .cw_mem(c_cw_mem), .cw_wb(c_cw_wb), .fwd_a(c_fwd_a), .fwd_b(c_fwd_b),
        .stall_fe(c_stall_fe), .flush_fe(c_flush_fe));

    function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] i_jal(input logic [4:0] rd);
        return {20'd0, rd, 7'b1101111};
    endfunction

    task automatic chk_cw(input string tag, input logic [CW_LENGTH-1:0] got, input logic [CW_LENGTH-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [CW_LENGTH-1:0] e, input logic [CW_LENGTH-1:0] m,
                            input logic [CW_LENGTH-1:0] w, input logic [1:0] fa, input logic [1:0] fb,
                            input logic st, input logic fl);
        chk_cw({tag, ".cw_ex"}, e, CW_NOP);
        chk_cw({tag, ".cw_mem"}, m, CW_NOP);
        chk_cw({tag, ".cw_wb"}, w, CW_NOP);
        chk_sel({tag, ".fwd_a"}, fa, 2'b00);
        chk_sel({tag, ".fwd_b"}, fb, 2'b00);
        chk_bit({tag, ".stall_fe"}, st, 1'b0);
        chk_bit({tag, ".flush_fe"}, fl, 1'b0);
    endtask

    // Advance one edge and land 2 time units after it, away from the active edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        nrst = 1'b1; stall_in = 1'b0; branch_taken = 1'b0;
        instr_a = 32'h0; instr_b = 32'h0; instr_c = 32'h0;
        #1 nrst = 1'b0;
        instr_a = i_add(5'd4, 5'd3, 5'd2);
        #11;
        // Reset state with an ADD waiting in IF/ID (edge at t=5 occurred under reset)
        chk_idle("rst_a", a_cw_ex, a_cw_mem, a_cw_wb, a_fwd_a, a_fwd_b, a_stall_fe, a_flush_fe);
        chk_idle("rst_b", b_cw_ex, b_cw_mem, b_cw_wb, b_fwd_a, b_fwd_b, b_stall_fe, b_flush_fe);
        chk_idle("rst_c", c_cw_ex, c_cw_mem, c_cw_wb, c_fwd_a, c_fwd_b, c_stall_fe, c_flush_fe);
        nrst = 1'b1;
        tick();
        chk_cw("first_add_ex", a_cw_ex, CW_ADD);
        chk_cw("first_add_mem", a_cw_mem, CW_NOP);

        // ALU-ALU dependency: forwarded from MEM, no stall
        instr_a = i_add(5'd5, 5'd4, 5'd2);
        #1;
        chk_bit("alu_dep_stall", a_stall_fe, 1'b0);
        chk_bit("alu_dep_flush", a_flush_fe, 1'b0);
        tick();
        chk_cw("alu_dep_ex", a_cw_ex, CW_ADD);
        chk_cw("alu_dep_mem", a_cw_mem, CW_ADD);
        chk_sel("alu_dep_fwd_a", a_fwd_a, 2'b01);
        chk_sel("alu_dep_fwd_b", a_fwd_b, 2'b00);

        // x0 producer/consumer never forwards
        instr_a = i_add(5'd0, 5'd3, 5'd2);
        tick();
        instr_a = i_add(5'd5, 5'd0, 5'd2);
        #1;
        chk_bit("x0_stall", a_stall_fe, 1'b0);
        tick();
        chk_sel("x0_fwd_a", a_fwd_a, 2'b00);

        // Producer two ahead: forwarded from WB
        instr_a = i_add(5'd6, 5'd3, 5'd2);
        tick();
        instr_a = 32'h0;
        tick();
        instr_a = i_add(5'd7, 5'd1, 5'd6);
        tick();
        chk_sel("wb_fwd_b", a_fwd_b, 2'b10);
        chk_sel("wb_fwd_a", a_fwd_a, 2'b00);

        // Same register written by MEM and WB: MEM wins
        instr_a = i_add(5'd8, 5'd3, 5'd2);
        tick();
        instr_a = i_add(5'd8, 5'd1, 5'd2);
        tick();
        instr_a = i_add(5'd9, 5'd8, 5'd8);
        tick();
        chk_sel("prio_fwd_a", a_fwd_a, 2'b01);
        chk_sel("prio_fwd_b", a_fwd_b, 2'b01);
        instr_a = 32'h0;
        repeat (3) tick();

        // Load-use, LOAD_LAT=1: one bubble then forward from WB
        instr_a = i_lw(5'd4, 5'd1);
        tick();
        instr_a = i_add(5'd5, 5'd4, 5'd2);
        #1;
        chk_bit("lu1_stall", a_stall_fe, 1'b1);
        chk_bit("lu1_flush", a_flush_fe, 1'b0);
        tick();
        chk_cw("lu1_bubble_ex", a_cw_ex, CW_NOP);
        chk_cw("lu1_load_mem", a_cw_mem, CW_LW);
        chk_bit("lu1_stall_clear", a_stall_fe, 1'b0);
        tick();
        chk_cw("lu1_use_ex", a_cw_ex, CW_ADD);
        chk_cw("lu1_load_wb", a_cw_wb, CW_LW);
        chk_sel("lu1_fwd_a", a_fwd_a, 2'b10);
        instr_a = 32'h0;
        repeat (3) tick();

        // JAL: one-cycle flush, own control word enters EX
        instr_a = i_jal(5'd1);
        #1;
        chk_bit("jal_flush", a_flush_fe, 1'b1);
        chk_bit("jal_stall", a_stall_fe, 1'b0);
        tick();
        chk_cw("jal_ex", a_cw_ex, CW_JAL);
        instr_a = 32'h0;
        #1;
        chk_bit("jal_flush_end", a_flush_fe, 1'b0);

        // Taken branch during a load-use hazard: flush, not stall
        instr_a = i_lw(5'd4, 5'd1);
        tick();
        instr_a = i_add(5'd5, 5'd4, 5'd2);
        branch_taken = 1'b1;
        #1;
        chk_bit("br_hz_flush", a_flush_fe, 1'b1);
        chk_bit("br_hz_stall", a_stall_fe, 1'b0);
        tick();
        chk_cw("br_hz_ex", a_cw_ex, CW_NOP);
        chk_cw("br_hz_mem", a_cw_mem, CW_LW);
        branch_taken = 1'b0;
        instr_a = 32'h0;
        repeat (2) tick();

        // Global freeze for 3 cycles, with a branch asserted to confirm stall_in priority
        instr_a = i_add(5'd4, 5'd3, 5'd2);
        tick();
        instr_a = i_add(5'd5, 5'd4, 5'd2);
        tick();
        instr_a = i_lw(5'd6, 5'd1);
        stall_in = 1'b1;
        branch_taken = 1'b1;
        #1;
        chk_bit("frz_stall", a_stall_fe, 1'b1);
        chk_bit("frz_flush", a_flush_fe, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cw("frz_ex", a_cw_ex, CW_ADD);
            chk_cw("frz_mem", a_cw_mem, CW_ADD);
            chk_cw("frz_wb", a_cw_wb, CW_NOP);
            chk_sel("frz_fwd_a", a_fwd_a, 2'b01);
        end
        stall_in = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk_bit("frz_release_stall", a_stall_fe, 1'b0);
        tick();
        chk_cw("frz_after_ex", a_cw_ex, CW_LW);
        chk_cw("frz_after_mem", a_cw_mem, CW_ADD);
        chk_cw("frz_after_wb", a_cw_wb, CW_ADD);

        // Asynchronous reset with words in flight
        nrst = 1'b0;
        #1;
        chk_cw("arst_ex", a_cw_ex, CW_NOP);
        chk_cw("arst_mem", a_cw_mem, CW_NOP);
        chk_cw("arst_wb", a_cw_wb, CW_NOP);
        nrst = 1'b1;
        instr_a = 32'h0;

        // Load-use, LOAD_LAT=2: two bubbles, consumer reads the register file
        instr_b = i_lw(5'd4, 5'd1);
        tick();
        instr_b = i_add(5'd5, 5'd4, 5'd2);
        #1;
        chk_bit("lu2_stall0", b_stall_fe, 1'b1);
        tick();
        chk_cw("lu2_bubble1", b_cw_ex, CW_NOP);
        chk_bit("lu2_stall1", b_stall_fe, 1'b1);
        tick();
        chk_cw("lu2_bubble2", b_cw_ex, CW_NOP);
        chk_cw("lu2_load_wb", b_cw_wb, CW_LW);
        chk_bit("lu2_stall2", b_stall_fe, 1'b0);
        tick();
        chk_cw("lu2_use_ex", b_cw_ex, CW_ADD);
        chk_sel("lu2_fwd_a", b_fwd_a, 2'b00);
        instr_b = 32'h0;

        // No forwarding: ALU dependency interlocks for two cycles
        instr_c = i_add(5'd4, 5'd3, 5'd2);
        tick();
        instr_c = i_add(5'd5, 5'd4, 5'd2);
        #1;
        chk_bit("nf_stall0", c_stall_fe, 1'b1);
        tick();
        chk_cw("nf_bubble1", c_cw_ex, CW_NOP);
        chk_bit("nf_stall1", c_stall_fe, 1'b1);
        tick();
        chk_cw("nf_bubble2", c_cw_ex, CW_NOP);
        chk_bit("nf_stall2", c_stall_fe, 1'b0);
        tick();
        chk_cw("nf_use_ex", c_cw_ex, CW_ADD);
        chk_sel("nf_fwd_a", c_fwd_a, 2'b00);
        instr_c = 32'h0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cu_hazard.md
# cu_hazard

Parametrised successor to the single-issue control unit: decodes the IF/ID instruction into a control word and pipelines it through EX, MEM and WB. It also owns hazard handling:
- load-use and RAW interlock with a configurable load latency;
- EX-stage forwarding selects;
- front-end flush on jumps and taken branches;
- a global freeze.

It sits between the IF/ID register and the datapath stage registers and replaces the external `stall`/`chng2nop` drive with internally generated `stall_fe`/`flush_fe`.

## Interface
Reset: one clock; reset is asynchronous and active-low.

Parameters:
- INSTR_W, default `instr_size` (32): instruction width.
- REG_AW, default 5: register address width.
- LOAD_LAT, default 1 (legal 1..2): stages after EX before load data is forwardable.
- FWD_EN, default 1: 1 = forwarding enabled; 0 = interlock on every RAW hazard.

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- instr_in  in  INSTR_W  instruction in IF/ID
- stall_in  in  1  global freeze (memory busy)
- branch_taken  in  1  branch resolved taken in EX
- cw_ex  out  `cw_length`  control word, EX stage
- cw_mem  out  `cw_length`  control word, MEM stage
- cw_wb  out  `cw_length`  control word, WB stage
- fwd_a  out  2  EX operand A source: 00 regfile, 01 MEM, 10 WB
- fwd_b  out  2  EX operand B source, same encoding
- stall_fe  out  1  freeze PC and IF/ID
- flush_fe  out  1  replace IF/ID content with NOP

## Operation
- Decode: `cw_decoder` maps opcode/funct to a cw_t. Per-stage registers also carry:
  - rd, rs1, rs2;
  - reg_we, mem_rd, uses_rs1, uses_rs2, is_jump.
- Advance: unless stall_in, each rising edge performs cw_wb←cw_mem, cw_mem←cw_ex, and cw_ex←(kill ? NOP : decode(instr_in)).
- Kill (bubble into EX): branch_taken OR hazard.
- Hazard, FWD_EN=1:
  - Condition: the ID instruction uses rs1/rs2 equal to rd of a mem_rd producer in stage k < LOAD_LAT (k=0 EX, k=1 MEM).
  - Result: one bubble per cycle until the producer passes stage LOAD_LAT−1.
- Hazard, FWD_EN=0: a reg_we producer in EX or MEM with rd matching a used rs.
- Register file: write-first, so WB producers never cause a hazard.
- x0: rd=0 never creates a hazard or a forward.
- Forwarding (FWD_EN=1), for rsX of the EX instruction:
  - MEM reg_we, non-load, rd match → 01;
  - else WB reg_we rd match → 10;
  - else 00.
  - MEM has priority over WB.
  - A load in MEM is never forwarded: the interlock guarantees this.
- FWD_EN=0: fwd_a/fwd_b are constant 00.
- stall_fe = stall_in | (hazard & !branch_taken).
- flush_fe = !stall_in & (branch_taken | (is_jump(ID) & !hazard)).
- Priority: stall_in > branch_taken > hazard > normal.
- stall_in: all stage registers hold; flush_fe is forced 0.

## Timing
- Reset values: all stage CW registers = NOP (all zeros: no reg/mem writes); carried rd/rs = 0; fwd_a = fwd_b = 00; stall_fe = 0 and flush_fe = 0 with inputs low.
- Reset mid-operation clears all in-flight words immediately (asynchronous).
- Latency: instr_in sampled at edge n appears in cw_ex after edge n, cw_mem after n+1, cw_wb after n+2.
- stall_fe, flush_fe and fwd_* are combinational from current state plus inputs, valid in the same cycle.
- Load-use penalty: LOAD_LAT bubbles.
  - LOAD_LAT=1: the consumer reaches EX with fwd=10.
  - LOAD_LAT=2: the consumer reads the register file.
- branch_taken coinciding with a hazard: a flush, not a stall; exactly one NOP enters EX.
- JAL/JALR: flush_fe for one cycle. The jump's own CW enters EX normally.

## Structure
- Package `cu_pkg`:
  - cw_t packed struct (alu_op, reg_we, mem_rd, mem_wr, is_jump, is_branch, uses_rs1, uses_rs2), width = `cw_length`;
  - NOP constant;
  - fwd_sel_t enum.
  - Opcodes come from `constants.sv`.
- Sub-module `cw_decoder`: purely combinational opcode→cw_t.
- Top: stage registers, hazard comparators, forwarding logic.

## Test plan
- Reset: nrst=0 with an ADD on instr_in → cw_ex/mem/wb = NOP, fwd=00, stall_fe=0, flush_fe=0; after release, the ADD CW appears in cw_ex one edge later.
- ADD x4,x3,x2 then ADD x5,x4,x2, FWD_EN=1 → no stall; second ADD in EX has fwd_a=01. Repeat with rd=x0 → fwd_a=00.
- LD x4 then ADD x5,x4,x2:
  - LOAD_LAT=1 → stall_fe=1 for 1 cycle, one NOP in cw_ex, then fwd_a=10.
  - LOAD_LAT=2 → 2 bubbles, fwd_a=00.
- FWD_EN=0, same ADD pair → 2 bubbles, fwd always 00.
- JAL in ID → flush_fe=1 for one cycle, cw_ex = JAL CW. branch_taken during a load-use hazard → flush_fe=1, stall_fe=0, NOP in cw_ex.
- stall_in high for 3 cycles mid-sequence → all cw_* held, stall_fe=1, flush_fe=0; after release, the output sequence matches the unstalled run shifted by 3.
